led7seg_scan: RTL and testbench

Parametrised multiplexed 7-segment display driver for the FPGA board's common-anode digit banks. It generalises the fixed 4-digit scanner to NDIGITS digits, adds tear-free double-buffered loading, per-digit blanking and decimal points, leading-zero suppression and PWM brightness. It sits between the debug/status registers of the core and the board's active-low segment and digit-select pins.

---
 rtl/led7seg_scan.sv | 190 +++++++++++++++++++
 tb/tb_led7seg_scan.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led7seg_scan.sv
// rtl/led7seg_scan.sv - multiplexed common-anode 7-segment scanner with double-buffered loading
//
// Purpose: scans NDIGITS hex digits onto shared active-low segment lines,
// one digit per 2^SCAN_BITS clocks. New values are staged on load and
// copied into the displayed (shadow) set only at the frame boundary, so a
// frame never mixes old and new digits. Also does per-digit blank and
// decimal point, leading-zero suppression and PWM brightness.
//
// Ports:
//   clk      system clock
//   rst_n    synchronous active-low reset
//   data     4*NDIGITS hex nibbles, digit 0 = data[3:0] (rightmost)
//   dp       per-digit decimal point, 1 = lit
//   blank    per-digit blank, 1 = dark
//   load     stage data/dp/blank for the next frame
//   lzs      leading-zero suppression enable (live)
//   bright   PWM duty level (live)
//   seg      segments a..g,dp on bits 7..0, active low, registered
//   segsel   digit select, active low, registered, at most one bit low
//   pending  staged values waiting for the frame boundary
//   frame    one-cycle pulse with the first digit-0 output of a frame
module led7seg_scan #(
  parameter int NDIGITS     = 4,
  parameter int SCAN_BITS   = 17,
  parameter int BRIGHT_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NDIGITS-1:0]   data,
  input  logic [NDIGITS-1:0]     dp,
  input  logic [NDIGITS-1:0]     blank,
  input  logic                   load,
  input  logic                   lzs,
  input  logic [BRIGHT_BITS-1:0] bright,
  output logic [7:0]             seg,
  output logic [NDIGITS-1:0]     segsel,
  output logic                   pending,
  output logic                   frame
);

  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);

  logic [SCAN_BITS-1:0]   prescaler_q, prescaler_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*NDIGITS-1:0]   stage_data_q, stage_data_d;
  logic [NDIGITS-1:0]     stage_dp_q, stage_dp_d;
  logic [NDIGITS-1:0]     stage_blank_q, stage_blank_d;
  logic [4*NDIGITS-1:0]   shadow_data_q, shadow_data_d;
  logic [NDIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic [NDIGITS-1:0]     shadow_blank_q, shadow_blank_d;
  logic                   pending_q, pending_d;
  logic                   frame_q, frame_d;
  logic [7:0]             seg_q, seg_d;
  logic [NDIGITS-1:0]     segsel_q, segsel_d;

  logic                   wrap;
  logic [3:0]             cur_nib;
  logic                   cur_dp;
  logic                   cur_blank;
  logic                   cur_upper_zero;
  logic [BRIGHT_BITS-1:0] pwm_field;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 8'h03;
      4'h1: hex_to_seg = 8'h9F;
      4'h2: hex_to_seg = 8'h25;
      4'h3: hex_to_seg = 8'h0D;
      4'h4: hex_to_seg = 8'h99;
      4'h5: hex_to_seg = 8'h49;
      4'h6: hex_to_seg = 8'h41;
      4'h7: hex_to_seg = 8'h1F;
      4'h8: hex_to_seg = 8'h01;
      4'h9: hex_to_seg = 8'h09;
      4'hA: hex_to_seg = 8'h11;
      4'hB: hex_to_seg = 8'hC1;
      4'hC: hex_to_seg = 8'h63;
      4'hD: hex_to_seg = 8'h85;
      4'hE: hex_to_seg = 8'h61;
      default: hex_to_seg = 8'h71;
    endcase
  endfunction

  always_comb begin
    wrap           = (&prescaler_q) && (idx_q == LAST_IDX);
    prescaler_d    = prescaler_q + SCAN_BITS'(1);
    idx_d          = idx_q;
    stage_data_d   = stage_data_q;
    stage_dp_d     = stage_dp_q;
    stage_blank_d  = stage_blank_q;
    shadow_data_d  = shadow_data_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    pending_d      = pending_q;
    frame_d        = wrap;
    cur_nib        = 4'h0;
    cur_dp         = 1'b0;
    cur_blank      = 1'b1;
    cur_upper_zero = 1'b0;
    seg_d          = 8'hFF;
    segsel_d       = '1;

    if (&prescaler_q) begin
      idx_d = wrap ? '0 : idx_q + IW'(1);
    end

    if (load) begin
      stage_data_d  = data;
      stage_dp_d    = dp;
      stage_blank_d = blank;
      pending_d     = 1'b1;
    end

    // A load in the wrap cycle itself bypasses staging and goes straight
    // to the shadow, so pending never rises for it.
    if (wrap) begin
      pending_d = 1'b0;
      if (load) begin
        shadow_data_d  = data;
        shadow_dp_d    = dp;
        shadow_blank_d = blank;
      end else if (pending_q) begin
        shadow_data_d  = stage_data_q;
        shadow_dp_d    = stage_dp_q;
        shadow_blank_d = stage_blank_q;
      end
    end

    // Outputs are built from the next-cycle state so that the registered
    // seg/segsel line up with frame: the first digit-0 output of the new
    // shadow appears in the same cycle as the frame pulse.
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        cur_nib        = shadow_data_d[4*i +: 4];
        cur_dp         = shadow_dp_d[i];
        cur_blank      = shadow_blank_d[i];
        cur_upper_zero = ~|(shadow_data_d >> (4*i));
      end
    end

    pwm_field = prescaler_d[SCAN_BITS-1 -: BRIGHT_BITS];

    if (!cur_blank && (pwm_field <= bright)) begin
      segsel_d = ~(NDIGITS'(1) << idx_d);
      if (lzs && (idx_d != '0) && cur_upper_zero) begin
        seg_d = 8'hFF;
      end else begin
        seg_d = hex_to_seg(cur_nib);
      end
      seg_d[0] = ~cur_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler_q    <= '0;
      idx_q          <= '0;
      stage_data_q   <= '0;
      stage_dp_q     <= '0;
      stage_blank_q  <= '1;
      shadow_data_q  <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '1;
      pending_q      <= 1'b0;
      frame_q        <= 1'b0;
      seg_q          <= 8'hFF;
      segsel_q       <= '1;
    end else begin
      prescaler_q    <= prescaler_d;
      idx_q          <= idx_d;
      stage_data_q   <= stage_data_d;
      stage_dp_q     <= stage_dp_d;
      stage_blank_q  <= stage_blank_d;
      shadow_data_q  <= shadow_data_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      pending_q      <= pending_d;
      frame_q        <= frame_d;
      seg_q          <= seg_d;
      segsel_q       <= segsel_d;
    end
  end

  assign seg     = seg_q;
  assign segsel  = segsel_q;
  assign pending = pending_q;
  assign frame   = frame_q;

endmodule

// File: tb/tb_led7seg_scan.sv
// tb/tb_led7seg_scan.sv - self-checking bench for led7seg_scan
module tb_led7seg_scan;

  localparam int ND    = 4;
  localparam int SB    = 4;
  localparam int BB    = 2;
  localparam int DLEN  = 1 << SB;
  localparam int FRAME = ND * DLEN;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4*ND-1:0] data;
  logic [ND-1:0] dp;
  logic [ND-1:0] blank;
  logic          load;
  logic          lzs;
  logic [BB-1:0] bright;
  logic [7:0]    seg;
  logic [ND-1:0] segsel;
  logic          pending;
  logic          frame;

  int checks = 0;
  int errors = 0;

  led7seg_scan #(.NDIGITS(ND), .SCAN_BITS(SB), .BRIGHT_BITS(BB)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .dp(dp), .blank(blank),
    .load(load), .lzs(lzs), .bright(bright), .seg(seg), .segsel(segsel),
    .pending(pending), .frame(frame)
  );

  always #5 clk = ~clk;

  logic [7:0] dec_tab [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: scan position is one number 0..FRAME-1; digit and
  // PWM phase fall out of it by division.
  int              m_cnt;
  logic [4*ND-1:0] m_st_data, m_sh_data;
  logic [ND-1:0]   m_st_dp, m_sh_dp, m_st_blank, m_sh_blank;
  logic            m_pend;
  logic            m_valid = 1'b0;
  logic            e_frame;
  logic [7:0]      e_seg;
  logic [ND-1:0]   e_segsel;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt = 0;
      m_st_data = '0; m_st_dp = '0; m_st_blank = '1;
      m_sh_data = '0; m_sh_dp = '0; m_sh_blank = '1;
      m_pend = 1'b0; e_frame = 1'b0; e_seg = 8'hFF; e_segsel = '1;
      m_valid = 1'b1;
    end else begin
      int d, field;
      logic wrap;
      wrap = (m_cnt == FRAME - 1);
      e_frame = wrap;
      if (wrap && load) begin
        m_sh_data = data; m_sh_dp = dp; m_sh_blank = blank;
      end else if (wrap && m_pend) begin
        m_sh_data = m_st_data; m_sh_dp = m_st_dp; m_sh_blank = m_st_blank;
      end
      if (load) begin
        m_st_data = data; m_st_dp = dp; m_st_blank = blank;
      end
      m_pend = wrap ? 1'b0 : (load ? 1'b1 : m_pend);
      m_cnt = (m_cnt + 1) % FRAME;
      d = m_cnt / DLEN;
      field = (m_cnt % DLEN) / (1 << (SB - BB));
      e_seg = 8'hFF;
      e_segsel = '1;
      if (field <= int'(bright) && !m_sh_blank[d]) begin
        e_segsel[d] = 1'b0;
        if (lzs && d > 0 && (m_sh_data >> (4*d)) == 0)
          e_seg = 8'hFF;
        else
          e_seg = dec_tab[(m_sh_data >> (4*d)) & 16'hF];
        if (m_sh_dp[d]) e_seg[0] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("seg", seg, e_seg);
      check("segsel", segsel, e_segsel);
      check("pending", pending, m_pend);
      check("frame", frame, e_frame);
      check("segsel_onehot", ($countones(~segsel) <= 1), 1);
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [4*ND-1:0] d, input logic [ND-1:0] p, input logic [ND-1:0] b);
    data = d; dp = p; blank = b; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while (frame !== 1'b1 && n < 2*FRAME) begin
      tick();
      n++;
    end
    check("frame_seen", frame, 1'b1);
  endtask

  int lit;

  initial begin
    dec_tab = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    rst_n = 1'b0; data = '0; dp = '0; blank = '0; load = 1'b0;
    lzs = 1'b0; bright = '1;
    tick(3);
    check("reset_seg", seg, 8'hFF);
    check("reset_segsel", segsel, 4'hF);
    check("reset_pending", pending, 1'b0);
    rst_n = 1'b1;
    tick(200);
    check("dark_segsel", segsel, 4'hF);

    // 12AF, all lit
    bright = 2'd3;
    do_load(16'h12AF, 4'h0, 4'h0);
    check("pending_after_load", pending, 1'b1);
    wait_frame();
    check("d0_seg", seg, 8'h71);
    check("d0_sel", segsel, 4'hE);
    tick(DLEN);
    check("d1_seg", seg, 8'h11);
    check("d1_sel", segsel, 4'hD);
    tick(DLEN);
    check("d2_seg", seg, 8'h25);
    tick(DLEN);
    check("d3_seg", seg, 8'h9F);
    check("d3_sel", segsel, 4'h7);

    // Last load before wrap wins, with leading-zero suppression
    lzs = 1'b1;
    do_load(16'h0000, 4'h0, 4'h0);
    do_load(16'h0005, 4'h0, 4'h0);
    wait_frame();
    check("lzs_d0", seg, 8'h49);
    tick(DLEN);
    check("lzs_d1_seg", seg, 8'hFF);
    check("lzs_d1_sel", segsel, 4'hD);
    do_load(16'h0005, 4'h4, 4'h0);
    wait_frame();
    tick(2*DLEN);
    check("lzs_d2_dp", seg, 8'hFE);

    // Brightness duty over a full frame
    bright = 2'd1;
    tick();
    lit = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (segsel != 4'hF) lit++;
    end
    check("duty_b1", lit, FRAME/2);
    bright = 2'd0;
    tick();
    lit = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (segsel != 4'hF) lit++;
    end
    check("duty_b0", lit, FRAME/4);

    bright = 2'd3;
    do_load(16'h4321, 4'h0, 4'b0100);
    wait_frame();
    lit = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (segsel[2] == 1'b0) lit++;
    end
    check("blank_d2", lit, 0);

    // Load exactly in the wrap cycle
    for (int i = 0; i < 2*FRAME && m_cnt != FRAME-1; i++) tick();
    check("at_wrap", m_cnt, FRAME-1);
    do_load(16'h3210, 4'h0, 4'h0);
    check("wrap_load_pending", pending, 1'b0);
    check("wrap_load_frame", frame, 1'b1);
    check("wrap_load_seg", seg, 8'h03);
    check("wrap_load_sel", segsel, 4'hE);

    // Reset mid-frame with staged data
    tick(20);
    do_load(16'hBEEF, 4'hF, 4'h0);
    tick(3);
    check("pre_reset_pending", pending, 1'b1);
    rst_n = 1'b0;
    tick();
    check("mid_reset_seg", seg, 8'hFF);
    check("mid_reset_sel", segsel, 4'hF);
    check("mid_reset_pending", pending, 1'b0);
    rst_n = 1'b1;
    tick(2*FRAME);
    check("post_reset_dark", segsel, 4'hF);

    // Randomized phase
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        data = 16'($urandom);
        if ($urandom_range(0, 2) == 0) data = data & 16'h000F;
        dp = 4'($urandom);
        blank = 4'($urandom & $urandom);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 49) == 0) bright = 2'($urandom);
      if ($urandom_range(0, 49) == 0) lzs = 1'($urandom);
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    load = 1'b0;
    rst_n = 1'b1;
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
